// File: rtl/mem_stream_reader_pkg.sv
// rtl/mem_stream_reader_pkg.sv - shared types and constants for the stream reader
package mem_stream_reader_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_stream_reader_if.sv
// rtl/mem_stream_reader_if.sv - RAM bus and pixel stream bundle
// Ports (signals):
//   mem_wr_en, mem_addr, mem_data_in : reader -> RAM
//   mem_rd_data, mem_rd_ack          : RAM -> reader (1-cycle read latency)
//   pix_data, pix_valid              : reader -> consumer
//   pix_ready                        : consumer -> reader
// master = reader side, slave = RAM/consumer side.
interface mem_stream_reader_if #(
    parameter int ADDR_BITS = 10
);
    import mem_stream_reader_pkg::*;

    logic                 mem_wr_en;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [WORD_W-1:0]    mem_data_in;
    logic [WORD_W-1:0]    mem_rd_data;
    logic                 mem_rd_ack;
    logic [WORD_W-1:0]    pix_data;
    logic                 pix_valid;
    logic                 pix_ready;

    modport master (
        output mem_wr_en, mem_addr, mem_data_in, pix_data, pix_valid,
        input  mem_rd_data, mem_rd_ack, pix_ready
    );

    modport slave (
        input  mem_wr_en, mem_addr, mem_data_in, pix_data, pix_valid,
        output mem_rd_data, mem_rd_ack, pix_ready
    );

endinterface

// File: rtl/mem_stream_reader_sync_fifo.sv
// rtl/mem_stream_reader_sync_fifo.sv - small synchronous FIFO used as prefetch buffer
// Ports:
//   clk, rst           : clock, synchronous active-high reset (flushes contents)
//   push, push_data    : write a word (ignored when full)
//   pop                : drop head word (ignored when empty)
//   full, empty, count : occupancy
//   head_data          : head word, 0 while empty
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_stream_reader.sv
// rtl/mem_stream_reader.sv - streams LEN RAM words through a prefetch FIFO, host writes take priority
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : pulse, begins a stream when idle
//   host_wr/addr/data   : host write request, wins the RAM port that cycle
//   bus (master)        : RAM bus (mem_*) and pixel stream (pix_*)
//   busy                : stream in progress
//   done                : one-cycle pulse after the last word is popped
module mem_stream_reader
    import mem_stream_reader_pkg::*;
#(
    parameter int RAM_ADDR_BITS = 10,
    parameter int BASE_ADDR     = 0,
    parameter int LEN           = 1024,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     host_wr,
    input  logic [RAM_ADDR_BITS-1:0] host_addr,
    input  logic [WORD_W-1:0]        host_data,
    mem_stream_reader_if.master      bus,
    output logic                     busy,
    output logic                     done
);
    localparam int CNT_W = $clog2(LEN+1);
    localparam int FCW   = $clog2(FIFO_DEPTH+1);
    localparam logic [CNT_W-1:0] LEN_C   = CNT_W'(LEN);
    localparam logic [CNT_W-1:0] LEN_M1  = CNT_W'(LEN-1);
    localparam logic [FCW:0]     DEPTH_C = (FCW+1)'(FIFO_DEPTH);

    state_t                   state, state_nxt;
    logic [RAM_ADDR_BITS-1:0] rd_addr;
    logic [CNT_W-1:0]         issued;
    logic [CNT_W-1:0]         popped;
    logic                     inflight;
    logic                     done_q;
    logic                     rd_issue;
    logic                     last_pop;
    logic                     push;
    logic                     nak;
    logic                     pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [FCW-1:0]           fifo_count;
    logic [FCW:0]             credit;

    // Words already in the FIFO plus the one on its way from the RAM.
    assign credit = {1'b0, fifo_count} + {{FCW{1'b0}}, inflight};
    assign push   = inflight && bus.mem_rd_ack && !fifo_full;
    assign nak    = inflight && !bus.mem_rd_ack;
    assign pop    = bus.pix_valid && bus.pix_ready;

    assign bus.mem_wr_en   = host_wr;
    assign bus.mem_addr    = host_wr ? host_addr : rd_addr;
    assign bus.mem_data_in = host_wr ? host_data : '0;
    assign bus.pix_valid   = !fifo_empty;
    assign busy            = (state != ST_IDLE);
    assign done            = done_q;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.mem_rd_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head_data (bus.pix_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // A nak cycle issues nothing so the rewound address is re-requested in order.
    // Leaving STREAM waits for the last read to be acked, so DRAIN never sees a nak.
    always_comb begin
        state_nxt = state;
        rd_issue  = 1'b0;
        last_pop  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                rd_issue = !host_wr && !nak && (issued < LEN_C) && (credit < DEPTH_C);
                if ((issued == LEN_C) && !nak) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                last_pop = pop && (popped == LEN_M1);
                if (last_pop) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr  <= '0;
            issued   <= '0;
            popped   <= '0;
            inflight <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            inflight <= rd_issue;
            done_q   <= last_pop;
            if ((state == ST_IDLE) && start) begin
                rd_addr <= RAM_ADDR_BITS'(BASE_ADDR);
                issued  <= '0;
                popped  <= '0;
            end else begin
                if (nak) begin
                    rd_addr <= rd_addr - 1'b1;
                    issued  <= issued - 1'b1;
                end else if (rd_issue) begin
                    rd_addr <= rd_addr + 1'b1;
                    issued  <= issued + 1'b1;
                end
                if (pop) popped <= popped + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb/tb_mem_stream_reader.sv - self-checking bench for mem_stream_reader
module tb_mem_stream_reader;

    logic        clk;
    logic        rst;
    logic [2:0]  start;
    logic [2:0]  host_wr;
    logic [2:0]  pix_ready;
    logic [2:0]  drop_ack;
    logic [9:0]  host_addr;
    logic [31:0] host_data;
    logic [2:0]  pv;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  wr_o;
    logic [9:0]  maddr [3];
    logic [31:0] pd [3];

    int tests = 0;
    int fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: BASE 0 LEN 8, instance 1: BASE 1020 LEN 8, instance 2: BASE 0 LEN 16.
    for (genvar g = 0; g < 3; g++) begin : u
        localparam int BASE = (g == 1) ? 1020 : 0;
        localparam int SLEN = (g == 2) ? 16 : 8;

        mem_stream_reader_if #(.ADDR_BITS(10)) bus ();
        logic [31:0] ram [1024];

        mem_stream_reader #(
            .RAM_ADDR_BITS (10),
            .BASE_ADDR     (BASE),
            .LEN           (SLEN),
            .FIFO_DEPTH    (4)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start[g]),
            .host_wr   (host_wr[g]),
            .host_addr (host_addr),
            .host_data (host_data),
            .bus       (bus),
            .busy      (busy[g]),
            .done      (done[g])
        );

        initial for (int i = 0; i < 1024; i++) ram[i] <= 32'(i);

        always @(posedge clk) begin
            if (bus.mem_wr_en) ram[bus.mem_addr] <= bus.mem_data_in;
            else               bus.mem_rd_data <= ram[bus.mem_addr];
            bus.mem_rd_ack <= !bus.mem_wr_en && !drop_ack[g];
        end

        assign bus.pix_ready = pix_ready[g];
        assign pv[g]         = bus.pix_valid;
        assign pd[g]         = bus.pix_data;
        assign wr_o[g]       = bus.mem_wr_en;
        assign maddr[g]      = bus.mem_addr;
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if ({pv, busy, done} !== 9'b0) begin
            fails++;
            $display("FAIL reset_flags got pv=%b busy=%b done=%b expected all 0", pv, busy, done);
        end
        for (int d = 0; d < 3; d++) begin
            tests++;
            if (pd[d] !== 32'h0) begin
                fails++;
                $display("FAIL reset_pix_data dut%0d got %h expected 0", d, pd[d]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_stream();
        logic exp_pv, exp_busy, exp_done;
        pix_ready[0] = 1'b1;
        for (int n = 0; n <= 12; n++) begin
            @(negedge clk);
            start[0] = (n == 0);
            #1;
            if (n == 0) continue;
            exp_pv   = (n >= 3) && (n <= 10);
            exp_busy = (n <= 10);
            exp_done = (n == 11);
            tests++;
            if ({pv[0], busy[0], done[0]} !== {exp_pv, exp_busy, exp_done} ||
                (exp_pv && pd[0] !== 32'(n - 3))) begin
                fails++;
                $display("FAIL basic cycle%0d got pv=%b busy=%b done=%b data=%h expected pv=%b busy=%b done=%b data=%0d",
                         n, pv[0], busy[0], done[0], pd[0], exp_pv, exp_busy, exp_done, n - 3);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] got[$];
        int stall = 0;
        int ndone = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            start[0] = (n == 0);
            if (got.size() == 2 && stall < 10) begin
                pix_ready[0] = 1'b0;
                stall++;
            end else begin
                pix_ready[0] = 1'b1;
            end
            #1;
            if (!pix_ready[0] && stall >= 4) begin
                tests++;
                if (maddr[0] !== 10'(got.size() + 4) || pv[0] !== 1'b1) begin
                    fails++;
                    $display("FAIL stall_full stall%0d got addr=%0d pv=%b expected addr=%0d pv=1",
                             stall, maddr[0], pv[0], got.size() + 4);
                end
            end
            if (pv[0] && pix_ready[0]) got.push_back(pd[0]);
            if (done[0]) ndone++;
        end
        tests++;
        if (got.size() != 8 || ndone != 1) begin
            fails++;
            $display("FAIL stall_count got words=%0d done=%0d expected 8/1", got.size(), ndone);
        end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            tests++;
            if (got[i] !== 32'(i)) begin
                fails++;
                $display("FAIL stall_word%0d got %h expected %h", i, got[i], i);
            end
        end
    endtask

    task automatic test_host_write();
        logic [31:0] got[$];
        int ndone = 0;
        pix_ready[0] = 1'b1;
        host_addr    = 10'h3F0;
        host_data    = 32'hDEAD_BEEF;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            start[0]   = (n == 0);
            host_wr[0] = (n % 2 == 0) && (n < 24);
            #1;
            if (host_wr[0]) begin
                tests++;
                if (wr_o[0] !== 1'b1 || maddr[0] !== 10'h3F0) begin
                    fails++;
                    $display("FAIL host_mux cycle%0d got wr_en=%b addr=%h expected 1/3f0", n, wr_o[0], maddr[0]);
                end
            end
            if (pv[0] && pix_ready[0]) got.push_back(pd[0]);
            if (done[0]) ndone++;
        end
        host_wr[0] = 1'b0;
        tests++;
        if (got.size() != 8 || ndone != 1) begin
            fails++;
            $display("FAIL host_count got words=%0d done=%0d expected 8/1", got.size(), ndone);
        end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            tests++;
            if (got[i] !== 32'(i)) begin
                fails++;
                $display("FAIL host_word%0d got %h expected %h", i, got[i], i);
            end
        end
        tests++;
        if (u[0].ram[10'h3F0] !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL host_ram got %h expected deadbeef", u[0].ram[10'h3F0]);
        end
    endtask

    task automatic test_ack_drop();
        logic [31:0] got[$];
        int ndone = 0;
        pix_ready[0] = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            start[0]    = (n == 0);
            drop_ack[0] = (n == 4) || (n == 10);
            #1;
            if (pv[0] && pix_ready[0]) got.push_back(pd[0]);
            if (done[0]) ndone++;
        end
        drop_ack[0] = 1'b0;
        tests++;
        if (got.size() != 8 || ndone != 1) begin
            fails++;
            $display("FAIL nak_count got words=%0d done=%0d expected 8/1", got.size(), ndone);
        end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            tests++;
            if (got[i] !== 32'(i)) begin
                fails++;
                $display("FAIL nak_word%0d got %h expected %h", i, got[i], i);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] got[$];
        int ndone = 0;
        pix_ready[1] = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            start[1] = (n == 0);
            #1;
            if (pv[1] && pix_ready[1]) got.push_back(pd[1]);
            if (done[1]) ndone++;
        end
        tests++;
        if (got.size() != 8 || ndone != 1) begin
            fails++;
            $display("FAIL wrap_count got words=%0d done=%0d expected 8/1", got.size(), ndone);
        end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            tests++;
            if (got[i] !== 32'((1020 + i) % 1024)) begin
                fails++;
                $display("FAIL wrap_word%0d got %0d expected %0d", i, got[i], (1020 + i) % 1024);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [31:0] got[$];
        int ndone  = 0;
        int rst_at = -1;
        pix_ready[2] = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            start[2] = (n == 0);
            rst      = (rst_at < 0) && (got.size() == 3);
            if (rst) rst_at = n;
            #1;
            if (rst_at >= 0 && n == rst_at + 1) begin
                tests++;
                if (pv[2] !== 1'b0 || busy[2] !== 1'b0) begin
                    fails++;
                    $display("FAIL rst_mid got pv=%b busy=%b expected 0/0", pv[2], busy[2]);
                end
            end
            if (rst_at < 0 && pv[2] && pix_ready[2]) got.push_back(pd[2]);
            if (rst_at >= 0 && done[2]) ndone++;
        end
        tests++;
        if (rst_at < 0 || ndone != 0 || got.size() != 3) begin
            fails++;
            $display("FAIL rst_mid_done got rst_cycle=%0d done=%0d words=%0d expected reset seen, 0 done, 3 words",
                     rst_at, ndone, got.size());
        end
        got.delete();
        ndone = 0;
        for (int n = 0; n < 35; n++) begin
            @(negedge clk);
            start[2] = (n == 0);
            #1;
            if (pv[2] && pix_ready[2]) got.push_back(pd[2]);
            if (done[2]) ndone++;
        end
        tests++;
        if (got.size() != 16 || ndone != 1) begin
            fails++;
            $display("FAIL restart_count got words=%0d done=%0d expected 16/1", got.size(), ndone);
        end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            tests++;
            if (got[i] !== 32'(i)) begin
                fails++;
                $display("FAIL restart_word%0d got %h expected %h", i, got[i], i);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] got[$];
        int ndone     = 0;
        int late_busy = 0;
        pix_ready[0] = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            start[0] = (n == 0) || (n == 3) || (n == 7) || (n == 10);
            #1;
            if (pv[0] && pix_ready[0]) got.push_back(pd[0]);
            if (done[0]) ndone++;
            if (n >= 12 && busy[0]) late_busy++;
        end
        start[0] = 1'b0;
        tests++;
        if (got.size() != 8 || ndone != 1 || late_busy != 0) begin
            fails++;
            $display("FAIL busy_start got words=%0d done=%0d late_busy=%0d expected 8/1/0",
                     got.size(), ndone, late_busy);
        end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            tests++;
            if (got[i] !== 32'(i)) begin
                fails++;
                $display("FAIL busy_word%0d got %h expected %h", i, got[i], i);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = '0;
        host_wr   = '0;
        pix_ready = '0;
        drop_ack  = '0;
        host_addr = '0;
        host_data = '0;
        test_reset();
        test_basic_stream();
        test_stall();
        test_host_write();
        test_ack_drop();
        test_wrap();
        test_reset_mid_stream();
        test_start_while_busy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
